// File: rtl/pe_acc_pipe_if.sv
// pe_acc_pipe_if -- beat input and result output handshakes of pe_acc_pipe.
// The master side drives beats and consumes results; the slave side is the
// accumulator pipeline itself.
interface pe_acc_pipe_if #(
   parameter int LANES = 32,
   parameter int IN_W  = 32,
   parameter int ACC_W = 32
) ();

   // Beat input: LANES signed lanes packed LSB-first, plus group terminator.
   logic                  in_valid;
   logic                  in_ready;
   logic [LANES*IN_W-1:0] in_data;
   logic                  in_last;

   // Result output: group sum and number of beats that formed it.
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_W-1:0]      out_data;
   logic [15:0]           out_beats;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_beats
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_beats
   );

endinterface : pe_acc_pipe_if

// File: rtl/pe_acc_pipe.sv
// pe_acc_pipe -- pipelined lane-reduction adder tree followed by a group
// accumulator. Each accepted beat is reduced to one sum by a registered
// binary tree of log2(LANES) levels; the accumulate stage adds tree sums
// into a running group total and publishes it, with a beat count, when a
// beat marked last reaches it. One global advance signal stalls the whole
// pipeline while a published result waits for the consumer.
module pe_acc_pipe #(
   parameter int LANES = 32,
   parameter int IN_W  = 32,
   parameter int ACC_W = 32
) (
   input logic          clk,
   input logic          rst,
   pe_acc_pipe_if.slave bus
);

   localparam int L     = $clog2(LANES);
   localparam int NODES = LANES - 1;      // internal (registered) tree nodes
   localparam int HEAP  = 2 * LANES - 1;  // leaves + internal nodes

   // The tree is stored as a heap: entries 0..LANES-1 are the sign-extended
   // input lanes, entry LANES+n is registered node n, and node n sums heap
   // entries 2n and 2n+1. Level boundaries fall out of this numbering, so the
   // last entry is the root (level L) and each level halves the operand count.
   logic [ACC_W-1:0] w_heap [HEAP];
   logic [ACC_W-1:0] r_node [NODES];

   // Per-level valid and last flags travelling alongside the tree sums.
   logic [L:1]       r_vld;
   logic [L:1]       r_lst;

   // Accumulate stage state.
   logic [ACC_W-1:0] r_acc;
   logic [15:0]      r_cnt;
   logic             r_start;

   // Registered outputs.
   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_data;
   logic [15:0]      r_out_beats;

   logic             w_adv;
   logic             w_tree_vld;
   logic             w_tree_lst;
   logic [ACC_W-1:0] w_tree_sum;
   logic [ACC_W-1:0] w_new_acc;
   logic [15:0]      w_new_cnt;

   // Everything moves unless a result is being held for the consumer.
   assign w_adv        = !(r_out_valid && !bus.out_ready);
   assign bus.in_ready = w_adv;

   // Build the heap view: sign-extended lanes followed by the tree registers.
   always_comb begin
      // NOTE: every array entry is assigned on every pass, so no latch can be
      // inferred; a combinational block that skips an element on some path
      // would silently turn that element into storage.
      for (int j = 0; j < LANES; j++) begin
         w_heap[j] = ACC_W'($signed(bus.in_data[IN_W*j +: IN_W]));
      end
      for (int n = 0; n < NODES; n++) begin
         w_heap[LANES+n] = r_node[n];
      end
   end

   // Tree sums: each registered node adds its odd child to its even child.
   always_ff @(posedge clk) begin
      // NOTE: the sum registers have no reset; the valid flags decide whether
      // their contents mean anything, and leaving them out of reset keeps
      // reset fan-out to the control bits only.
      if (w_adv) begin
         for (int n = 0; n < NODES; n++) begin
            r_node[n] <= w_heap[2*n+1] + w_heap[2*n];
         end
      end
   end

   // Tree control: valid/last shift one level per advancing cycle.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here let each level read the value its
      // predecessor held before this edge; blocking ones would collapse the
      // shift chain into a single cycle.
      if (rst) begin
         r_vld <= '0;
         r_lst <= '0;
      end else if (w_adv) begin
         r_vld[1] <= bus.in_valid;
         r_lst[1] <= bus.in_valid && bus.in_last;
         for (int k = 2; k <= L; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_lst[k] <= r_lst[k-1];
         end
      end
   end

   assign w_tree_vld = r_vld[L];
   assign w_tree_lst = r_lst[L];
   assign w_tree_sum = w_heap[HEAP-1];

   // A new group restarts both the sum and the count; the count sticks at max.
   assign w_new_acc = (r_start ? '0 : r_acc) + w_tree_sum;
   assign w_new_cnt = r_start              ? 16'd1 :
                      (r_cnt == 16'hFFFF)  ? r_cnt :
                                             r_cnt + 16'd1;

   // Accumulate stage and result register. When advancing, any held result
   // has just been taken, so out_valid follows only the incoming last beat;
   // that also gives back-to-back results without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_start     <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_beats <= '0;
      end else if (w_adv) begin
         r_out_valid <= w_tree_vld && w_tree_lst;
         if (w_tree_vld) begin
            r_acc   <= w_new_acc;
            r_cnt   <= w_new_cnt;
            r_start <= w_tree_lst;
            if (w_tree_lst) begin
               r_out_data  <= w_new_acc;
               r_out_beats <= w_new_cnt;
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_beats = r_out_beats;

endmodule : pe_acc_pipe

// File: tb/tb_pe_acc_pipe.sv
// tb_pe_acc_pipe -- directed bench for pe_acc_pipe with LANES=32,
// IN_W=ACC_W=32. Expected sums are worked out by hand for each step.
module tb_pe_acc_pipe;

   localparam int LANES = 32;
   localparam int IN_W  = 32;
   localparam int ACC_W = 32;

   logic clk;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   pe_acc_pipe_if #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) bus ();

   pe_acc_pipe #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a stimulus step never returns.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic [IN_W-1:0] v);
      for (int j = 0; j < LANES; j++) bus.in_data[IN_W*j +: IN_W] = v;
   endtask

   // Present the current in_data for one cycle; the block must be ready.
   task automatic push(input logic last);
      check("push_in_ready", bus.in_ready, 1);
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic send(input logic [IN_W-1:0] v, input logic last);
      set_all(v);
      push(last);
   endtask

   task automatic send_ramp(input logic last);
      for (int j = 0; j < LANES; j++) bus.in_data[IN_W*j +: IN_W] = j;
      push(last);
   endtask

   task automatic wait_out(input int max_cyc);
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < max_cyc) begin
         tick();
         n++;
      end
      check("wait_out_valid", bus.out_valid, 1);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      tick();
      tick();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_out_beats", bus.out_beats, 0);
      rst = 1'b0;
      tick();
      check("post_rst_in_ready",  bus.in_ready,  1);
      check("post_rst_out_valid", bus.out_valid, 0);

      // Single beat of all ones: result exactly six cycles after acceptance.
      set_all(32'd1);
      push(1'b1);
      check("lat_t1", bus.out_valid, 0);
      for (int k = 2; k <= 5; k++) begin
         tick();
         check("lat_early", bus.out_valid, 0);
      end
      tick();
      check("lat_t6_valid", bus.out_valid, 1);
      check("ones_data",    bus.out_data,  32);
      check("ones_beats",   bus.out_beats, 1);
      tick();
      check("ones_consumed", bus.out_valid, 0);

      // Three ramp beats with an ignored bubble before the last: 3*496.
      send_ramp(1'b0);
      send_ramp(1'b0);
      set_all(32'hDEAD_BEEF);
      bus.in_last = 1'b1;
      tick();
      bus.in_last = 1'b0;
      send_ramp(1'b1);
      wait_out(20);
      check("ramp_data",  bus.out_data,  1488);
      check("ramp_beats", bus.out_beats, 3);
      tick();
      check("ramp_consumed", bus.out_valid, 0);

      // Wrap and sign extension, as two back-to-back single-beat groups.
      bus.in_data = '0;
      bus.in_data[IN_W*0 +: IN_W] = 32'h7FFF_FFFF;
      bus.in_data[IN_W*1 +: IN_W] = 32'h7FFF_FFFF;
      push(1'b1);
      send(32'hFFFF_FFFF, 1'b1);
      wait_out(20);
      check("wrap_data",  bus.out_data,  32'hFFFF_FFFE);
      check("wrap_beats", bus.out_beats, 1);
      tick();
      check("neg_valid", bus.out_valid, 1);
      check("neg_data",  bus.out_data,  32'hFFFF_FFE0);
      tick();
      check("neg_consumed", bus.out_valid, 0);

      // Backpressure: first result held for ten cycles, then all three drain.
      bus.out_ready = 1'b0;
      send(32'd3, 1'b1);
      send(32'd4, 1'b1);
      send(32'd5, 1'b1);
      wait_out(20);
      check("bp_first_data", bus.out_data, 96);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_in_ready",  bus.in_ready,  0);
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_data", bus.out_data,  96);
         check("bp_hold_beats", bus.out_beats, 1);
      end
      bus.out_ready = 1'b1;
      tick();
      check("bp_second_valid", bus.out_valid, 1);
      check("bp_second_data",  bus.out_data,  128);
      tick();
      check("bp_third_valid", bus.out_valid, 1);
      check("bp_third_data",  bus.out_data,  160);
      tick();
      check("bp_drained", bus.out_valid, 0);

      // Reset in the middle of a group throws away the partial sum.
      send(32'd1, 1'b0);
      send(32'd1, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_out_valid", bus.out_valid, 0);
      send(32'd2, 1'b1);
      wait_out(20);
      check("midrst_data",  bus.out_data,  64);
      check("midrst_beats", bus.out_beats, 1);
      tick();
      check("midrst_consumed", bus.out_valid, 0);

      // Eight single-beat groups back to back: eight consecutive results.
      fork
         begin
            for (int k = 1; k <= 8; k++) send(k, 1'b1);
         end
         begin
            wait_out(20);
            for (int k = 1; k <= 8; k++) begin
               check("b2b_valid", bus.out_valid, 1);
               check("b2b_data",  bus.out_data,  32 * k);
               check("b2b_beats", bus.out_beats, 1);
               tick();
            end
            check("b2b_done", bus.out_valid, 0);
         end
      join

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_pe_acc_pipe
